uart_loader: RTL and testbench
==============================

# uart_loader

Byte-stream boot loader that sequences the UART receiver output into word writes on a simple memory request/grant port. It consumes bytes over a valid/ready handshake (driven by the UART receiver's `valid_o`/`data_o`/`ready_i`), parses a framed load command (sync, address, length, payload), and issues 32-bit word writes. It signals completion so the SoC can release the core from reset. Backpressure from memory is propagated to the receiver through `rx_ready_o`.

## Interface
- `ADDR_WIDTH`, 32: memory address width (≤32).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_valid_i` in 1: receiver byte valid.
- `rx_data_i` in 8: receiver byte.
- `rx_ready_o` out 1: byte accept; a transfer occurs when `rx_valid_i && rx_ready_o`.
- `mem_req_o` out 1: write request.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_we_o` out 1: equals `mem_req_o`.
- `mem_be_o` out 4: 4'hF while requesting, else 0.
- `mem_addr_o` out ADDR_WIDTH: word-aligned byte address.
- `mem_wdata_o` out 32: write data.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse after the last word of a frame is granted.
- `err_o` out 1: sticky timeout flag.

## Operation
- Frame format (all multibyte fields are little-endian): SYNC_BYTE, 4-byte start address, 4-byte word count N, then 4·N payload bytes.
- States:
  - **IDLE**: accepts bytes; non-sync bytes are discarded. On a sync byte, `err_o` clears, the byte counter clears, and the state goes to ADDR.
  - **ADDR**: assembles 4 bytes, then goes to LEN. Address bits [1:0] are forced to 0.
  - **LEN**: assembles 4 bytes. If N==0 the state goes to DONE; otherwise to DATA.
  - **DATA**: assembles 4 bytes into the word register, then goes to WRITE.
  - **WRITE**: `rx_ready_o`=0 and `mem_req_o`=1. Address and data stay stable until `mem_gnt_i`. On a grant the address increments by 4 (wrapping modulo 2^ADDR_WIDTH) and the remaining count decrements. If the remaining count reaches 0 the state goes to DONE; otherwise to DATA.
  - **DONE**: `done_o`=1 for one cycle, then IDLE.
- `rx_ready_o` = 1 in IDLE, ADDR, LEN and DATA; 0 in WRITE and DONE.
- Byte counter: 2 bits, shared across ADDR, LEN and DATA; it wraps 3→0 on each field completion.
- Timeout:
  - A 32-bit counter runs in ADDR, LEN and DATA, and clears on every accepted byte and on state entry.
  - It does not run in WRITE, so memory stalls never time out.
  - When it reaches TIMEOUT_CYCLES−1 without a byte, `err_o` is set, the state goes to IDLE, and no partial word is written.
- Remaining count is 32 bits. N is treated as unsigned, so N=0xFFFFFFFF is a legal frame.
- Reset is asynchronous to all registers: state IDLE, counters 0, `err_o`=0.

## Timing
- Reset values: `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `rx_ready_o`=1.
- The 4th payload byte accepted at cycle T gives `mem_req_o`=1 at T+1 (registered state).
- If granted at T+1, `rx_ready_o`=1 again at T+2.
- A grant on the first request cycle is legal, so minimum WRITE occupancy is 1 cycle.
- After the final grant at cycle G: `done_o`=1 at G+1 and `busy_o`=0 at G+2.
- `mem_addr_o` and `mem_wdata_o` change only on state entry to WRITE or on a grant. They hold their last values otherwise.
- `err_o` is set in the cycle after the timeout compare. It stays set until the next accepted sync byte.
- A sync byte received mid-frame is treated as data, with no resynchronization.
- Asynchronous reset mid-WRITE drops `mem_req_o` immediately. The partially loaded frame is abandoned.

## Test plan
- Frame A5, 00 10 00 00, 02 00 00 00, 78 56 34 12, EF BE AD DE with immediate grant → writes 0x12345678 @0x1000 and 0xDEADBEEF @0x1004; one `done_o` pulse; `err_o`=0.
- Same frame, with `mem_gnt_i` held low for 20 cycles on the first write → `rx_ready_o`=0 throughout; addr/data stable; exactly 2 grants; correct order.
- Junk bytes 00 FF 55, then A5, addr 0x0000_0003, N=1, payload 01 02 03 04 → junk ignored; write 0x04030201 @0x0000_0000.
- N=0 frame → no `mem_req_o`; `done_o` pulses 1 cycle after the last length byte.
- TIMEOUT_CYCLES=100: stop after 2 payload bytes → `err_o`=1 about 100 cycles later; no write; state IDLE; next A5 clears `err_o`.
- Address 0xFFFF_FFFC, N=2 → writes @0xFFFF_FFFC then @0x0000_0000 (wrap). Assert `rst_ni` mid-WRITE of a second frame → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: frames UART bytes (sync, addr, len, payload) into 32-bit memory word writes
module uart_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q;
  logic [23:0] sh_q;
  logic [31:0] addr_q, rem_q, tmo_q, nxt;
  logic err_q, acc, run, last, tmo_hit, sync;
  assign rx_ready_o = state_q inside {IDLE, ADDR, LEN, DATA};
  assign run = state_q inside {ADDR, LEN, DATA};
  assign acc = rx_valid_i && rx_ready_o;
  assign sync = acc && state_q == IDLE && rx_data_i == SYNC_BYTE;
  assign last = acc && run && cnt_q == 2'd3;
  assign nxt = {rx_data_i, sh_q};
  assign tmo_hit = run && !acc && tmo_q == TIMEOUT_CYCLES - 1;
  assign mem_req_o = state_q == WRITE;
  assign mem_we_o = mem_req_o;
  assign mem_be_o = {4{mem_req_o}};
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign err_o = err_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sync ? ADDR : IDLE;
      ADDR:    state_d = tmo_hit ? IDLE : last ? LEN : ADDR;
      LEN:     state_d = tmo_hit ? IDLE : !last ? LEN : nxt == 32'd0 ? DONE : DATA;
      DATA:    state_d = tmo_hit ? IDLE : last ? WRITE : DATA;
      WRITE:   state_d = !mem_gnt_i ? WRITE : rem_q == 32'd1 ? DONE : DATA;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= (!run || acc || state_d != state_q) ? '0 : tmo_q + 32'd1;
      if (sync) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end
      if (tmo_hit) err_q <= 1'b1;
      if (acc && run) begin
        cnt_q <= cnt_q + 2'd1;
        sh_q <= nxt[31:8];
      end
      if (last && state_q == ADDR) addr_q <= {nxt[31:2], 2'b00};
      if (last && state_q == LEN) rem_q <= nxt;
      if (last && state_q == DATA) begin
        mem_wdata_o <= nxt;
        mem_addr_o <= addr_q[ADDR_WIDTH-1:0];
      end
      if (mem_req_o && mem_gnt_i) begin
        addr_q <= addr_q + 32'd4;
        rem_q <= rem_q - 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed self-checking bench for uart_loader
module tb_uart_loader;
  logic clk_i = 0, rst_ni = 1, rx_valid_i = 0, mem_gnt_i = 0;
  logic [7:0] rx_data_i = 0;
  logic rx_ready_o, mem_req_o, mem_we_o, busy_o, done_o, err_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  int checks = 0, errors = 0;
  int stall_cnt = 0, wr_n = 0, done_n = 0, req_n = 0;
  logic [31:0] wr_addr [8], wr_data [8];

  uart_loader #(.ADDR_WIDTH(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_ready_o(rx_ready_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) done_n++;
    if (mem_req_o) req_n++;
    if (mem_req_o && stall_cnt > 0) begin
      mem_gnt_i = 0;
      stall_cnt--;
    end else if (mem_req_o) begin
      mem_gnt_i = 1;
      if (wr_n < 8) begin
        wr_addr[wr_n] = mem_addr_o;
        wr_data[wr_n] = mem_wdata_o;
      end
      wr_n++;
    end else mem_gnt_i = 0;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid_i = 1;
    rx_data_i = b;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_byte: rx_ready_o=%b, required 1 within 200 cycles", rx_ready_o);
    end
    @(negedge clk_i);
    rx_valid_i = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [31:0] n);
    send_byte(8'hA5);
    send_word(a);
    send_word(n);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy_o=%b, required 0 within 1000 cycles", busy_o);
    end
  endtask

  task automatic clear_log();
    wr_n = 0; done_n = 0; req_n = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, busy_o, done_o, err_o, rx_ready_o} !== 10'b0000000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required %b", {mem_req_o, mem_we_o, mem_be_o, busy_o, done_o, err_o, rx_ready_o}, 10'b0000000001);
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o} !== 64'd0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h, required 0/0", mem_addr_o, mem_wdata_o);
    end
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    clear_log();
    send_hdr(32'h0000_1000, 32'd2);
    send_word(32'h1234_5678);
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL req_latency: mem_req_o=%b, required 1", mem_req_o);
    end
    @(negedge clk_i);
    checks++;
    if (rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_grant: rx_ready_o=%b, required 1", rx_ready_o);
    end
    send_word(32'hDEAD_BEEF);
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL done_pulse: done/busy=%b, required 11", {done_o, busy_o});
    end
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL done_end: done/busy=%b, required 00", {done_o, busy_o});
    end
    checks++;
    if (wr_n !== 2 || {wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {32'h1000, 32'h1234_5678, 32'h1004, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL basic_writes: n=%0d %h@%h %h@%h, required 2 12345678@00001000 deadbeef@00001004", wr_n, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
    end
    checks++;
    if (done_n !== 1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done pulses=%0d err=%b, required 1 and 0", done_n, err_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a0, d0;
    int bad = 0;
    clear_log();
    stall_cnt = 20;
    send_hdr(32'h0000_1000, 32'd2);
    send_word(32'h1234_5678);
    a0 = mem_addr_o;
    d0 = mem_wdata_o;
    checks++;
    if (mem_req_o !== 1'b1 || {a0, d0} !== {32'h1000, 32'h1234_5678}) begin
      errors++;
      $display("FAIL stall_first_req: req=%b %h@%h, required 1 12345678@00001000", mem_req_o, d0, a0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rx_ready_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== a0 || mem_wdata_o !== d0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
    end
    send_word(32'hDEAD_BEEF);
    wait_idle();
    checks++;
    if (wr_n !== 2 || {wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {32'h1000, 32'h1234_5678, 32'h1004, 32'hDEAD_BEEF} || done_n !== 1) begin
      errors++;
      $display("FAIL stall_writes: n=%0d %h@%h %h@%h done=%0d, required 2 12345678@00001000 deadbeef@00001004 1", wr_n, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1], done_n);
    end
  endtask

  task automatic test_junk();
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h55);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL junk_idle: busy_o=%b, required 0", busy_o);
    end
    send_hdr(32'h0000_0003, 32'd1);
    send_word(32'h0403_0201);
    wait_idle();
    checks++;
    if (wr_n !== 1 || {wr_addr[0], wr_data[0]} !== {32'h0, 32'h0403_0201}) begin
      errors++;
      $display("FAIL junk_write: n=%0d %h@%h, required 1 04030201@00000000", wr_n, wr_data[0], wr_addr[0]);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    send_hdr(32'h0000_2000, 32'd0);
    checks++;
    if ({done_o, mem_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL zero_done: done/req=%b, required 10", {done_o, mem_req_o});
    end
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00 || req_n !== 0 || done_n !== 1) begin
      errors++;
      $display("FAIL zero_end: done/busy=%b reqs=%0d dones=%0d, required 00 0 1", {done_o, busy_o}, req_n, done_n);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_log();
    send_hdr(32'h0, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    while (!err_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n < 95 || n > 105) begin
      errors++;
      $display("FAIL timeout_delay: err after %0d cycles, required about 100", n);
    end
    checks++;
    if ({err_o, busy_o} !== 2'b10 || wr_n !== 0 || req_n !== 0) begin
      errors++;
      $display("FAIL timeout_state: err/busy=%b writes=%0d reqs=%0d, required 10 0 0", {err_o, busy_o}, wr_n, req_n);
    end
    send_byte(8'hA5);
    checks++;
    if ({err_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_clear: err/busy=%b, required 01", {err_o, busy_o});
    end
    send_word(32'h0000_3000);
    send_word(32'd0);
    wait_idle();
  endtask

  task automatic test_wrap();
    clear_log();
    send_hdr(32'hFFFF_FFFC, 32'd2);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    wait_idle();
    checks++;
    if (wr_n !== 2 || {wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {32'hFFFF_FFFC, 32'h1111_1111, 32'h0, 32'h2222_2222}) begin
      errors++;
      $display("FAIL wrap_writes: n=%0d %h@%h %h@%h, required 2 11111111@fffffffc 22222222@00000000", wr_n, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    clear_log();
    stall_cnt = 50;
    send_hdr(32'h0000_0100, 32'd1);
    send_word(32'hCAFE_F00D);
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req: mem_req_o=%b, required 1", mem_req_o);
    end
    #2 rst_ni = 0;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, busy_o, done_o, err_o, rx_ready_o} !== 10'b0000000001) begin
      errors++;
      $display("FAIL rst_async_ctrl: got %b, required %b", {mem_req_o, mem_we_o, mem_be_o, busy_o, done_o, err_o, rx_ready_o}, 10'b0000000001);
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o} !== 64'd0) begin
      errors++;
      $display("FAIL rst_async_addr_data: got %h/%h, required 0/0", mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    stall_cnt = 0;
    rst_ni = 1;
    @(negedge clk_i);
    checks++;
    if (wr_n !== 0) begin
      errors++;
      $display("FAIL rst_no_write: writes=%0d, required 0", wr_n);
    end
    send_hdr(32'h0000_0040, 32'd1);
    send_word(32'h55AA_55AA);
    wait_idle();
    checks++;
    if (wr_n !== 1 || {wr_addr[0], wr_data[0]} !== {32'h40, 32'h55AA_55AA}) begin
      errors++;
      $display("FAIL rst_recover: n=%0d %h@%h, required 1 55aa55aa@00000040", wr_n, wr_data[0], wr_addr[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_junk();
    test_zero_len();
    test_timeout();
    test_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
